ctrl_seq: RTL

Sequential, parametrised control unit for the 9-bit CSE141L core: decodes the fetched instruction into datapath enables, as the combinational decoder does, and adds multi-cycle load sequencing, taken-branch flush, halt handling and a retired-instruction counter.
- Sits between instruction ROM/ALU flags and the fetch unit, register file and data memory.
- Drives PC stall and pipeline flush.

---
 rtl/ctrl_seq_if.sv | 32 +++
 rtl/ctrl_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_if.sv
// ctrl_seq datapath-control bundle.
// master drives fetch-side inputs; slave is the control unit.
interface ctrl_seq_if #(
  parameter int IW = 9,
  parameter int CW = 16
);
  logic [IW-1:0] Instruction;
  logic          InstrValid;
  logic          BranchCond;
  logic          BranchEn;
  logic          RegWriteEn;
  logic          MemWriteEn;
  logic          MemReadEn;
  logic          PcStall;
  logic          Flush;
  logic          Done;
  logic [CW-1:0] RetireCount;

  modport master (
    output Instruction, InstrValid, BranchCond,
    input  BranchEn, RegWriteEn, MemWriteEn,
    input  MemReadEn, PcStall, Flush,
    input  Done, RetireCount
  );

  modport slave (
    input  Instruction, InstrValid, BranchCond,
    output BranchEn, RegWriteEn, MemWriteEn,
    output MemReadEn, PcStall, Flush,
    output Done, RetireCount
  );
endinterface

// File: rtl/ctrl_seq.sv
// Sequential control unit for the 9-bit core:
// decode, load wait, branch flush, halt, retire count.
module ctrl_seq #(
  parameter int IW        = 9,
  parameter int LD_LAT    = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CW        = 16
) (
  input  logic Clk,
  input  logic Reset,
  ctrl_seq_if.slave bus
);
  typedef enum logic [1:0] {
    RUN, LOAD_WAIT, FLUSH, HALTED
  } state_t;

  localparam logic [3:0] LD_INIT =
    4'(LD_LAT > 0 ? LD_LAT - 1 : 0);
  localparam logic [3:0] FL_INIT =
    4'(FLUSH_CYC > 0 ? FLUSH_CYC - 1 : 0);
  localparam logic [CW-1:0] ONE =
    {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_nstate;
  logic [3:0]    r_cnt;
  logic [3:0]    w_ncnt;
  logic [IW-1:0] r_instr;
  logic          r_done;
  logic [CW-1:0] r_ret;

  logic [IW-1:0] w_instr;
  logic [1:0]    w_op;
  logic [2:0]    w_fn3;
  logic [1:0]    w_fn2;
  logic          w_beq;
  logic          w_lb;
  logic          w_sb;
  logic          w_halt;
  logic          w_unused;

  logic w_be;
  logic w_rwe;
  logic w_mwe;
  logic w_mre;
  logic w_stall;
  logic w_flush;
  logic w_retire;
  logic w_capture;

  // During a load wait the captured LB drives decode.
  assign w_instr = (r_state == LOAD_WAIT) ?
                   r_instr : bus.Instruction;
  assign w_op    = w_instr[IW-1:IW-2];
  assign w_fn3   = w_instr[IW-3:IW-5];
  assign w_fn2   = w_instr[IW-3:IW-4];
  assign w_unused = ^w_instr[IW-6:0];

  assign w_beq  = (w_op == 2'b00) && (w_fn3 == 3'b000);
  assign w_lb   = (w_op == 2'b01) && (w_fn2 == 2'b00);
  assign w_sb   = (w_op == 2'b01) && (w_fn2 == 2'b01);
  assign w_halt = (w_op == 2'b11) && (w_fn3 == 3'b111);

  always_comb begin
    w_nstate  = r_state;
    w_ncnt    = r_cnt;
    w_be      = 1'b0;
    w_rwe     = 1'b0;
    w_mwe     = 1'b0;
    w_mre     = 1'b0;
    w_stall   = 1'b0;
    w_flush   = 1'b0;
    w_retire  = 1'b0;
    w_capture = 1'b0;
    if (Reset) begin
      w_nstate = RUN;
      w_ncnt   = 4'd0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (bus.InstrValid) begin
            unique case (1'b1)
              w_beq: begin
                w_be     = 1'b1;
                w_retire = 1'b1;
                if (bus.BranchCond && FLUSH_CYC > 0) begin
                  w_nstate = FLUSH;
                  w_ncnt   = FL_INIT;
                end
              end
              w_sb: begin
                w_mwe    = 1'b1;
                w_retire = 1'b1;
              end
              w_lb: begin
                w_mre = 1'b1;
                if (LD_LAT == 0) begin
                  w_rwe    = 1'b1;
                  w_retire = 1'b1;
                end else begin
                  w_stall   = 1'b1;
                  w_capture = 1'b1;
                  w_nstate  = LOAD_WAIT;
                  w_ncnt    = LD_INIT;
                end
              end
              w_halt: begin
                w_retire = 1'b1;
                w_nstate = HALTED;
              end
              default: begin
                w_rwe    = 1'b1;
                w_retire = 1'b1;
              end
            endcase
          end
        end
        LOAD_WAIT: begin
          w_mre = 1'b1;
          if (r_cnt != 4'd0) begin
            w_stall = 1'b1;
            w_ncnt  = r_cnt - 4'd1;
          end else begin
            w_rwe    = 1'b1;
            w_retire = 1'b1;
            w_nstate = RUN;
          end
        end
        FLUSH: begin
          w_flush = 1'b1;
          if (r_cnt == 4'd0) w_nstate = RUN;
          else               w_ncnt   = r_cnt - 4'd1;
        end
        HALTED: begin
          w_stall = 1'b1;
        end
        default: begin
          w_nstate = RUN;
          w_ncnt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
      r_instr <= '0;
      r_done  <= 1'b0;
      r_ret   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_done  <= (w_nstate == HALTED);
      if (w_capture) r_instr <= bus.Instruction;
      if (w_retire)  r_ret   <= r_ret + ONE;
    end
  end

  assign bus.BranchEn    = w_be;
  assign bus.RegWriteEn  = w_rwe;
  assign bus.MemWriteEn  = w_mwe;
  assign bus.MemReadEn   = w_mre;
  assign bus.PcStall     = w_stall;
  assign bus.Flush       = w_flush;
  assign bus.Done        = r_done;
  assign bus.RetireCount = r_ret;
endmodule
